rr_port_allocator: RTL and testbench
====================================

Name: rr_port_allocator

Overview:
- Per-router output-port allocator and credit tracker for the 5-port mesh router (ports N=0, S=1, E=2, W=3, L=4).
- Each cycle, each output port picks at most one requesting input port using round-robin priority, gated by downstream credits and the port mask.
- Drives the crossbar select, output-port send enable and input-FIFO pop.
- Replaces the free-running turn-based arbiter with demand-driven, credit-aware allocation. Corner and edge routers mask their absent ports.

Parameters:
CREDITS, 4, downstream input-FIFO depth; reset value and maximum of each credit counter.
CW, $clog2(CREDITS+1), local: credit counter width.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid_i  input  5  input port i has a head flit (FIFO read_valid)
req_dest_i  input  15  3-bit destination port per input; input i at [3i+2:3i]
credit_inc_i  input  5  output port j: downstream freed one slot (1-cycle pulse)
port_mask_i  input  5  1 = output port j exists; quasi-static
port_enable_o  output  5  output port j sends the selected flit this cycle
port_select_o  output  15  3-bit source input index per output j; 3'd7 when idle
port_remove_o  output  5  pop head flit of input i this cycle
credit_o  output  5*CW  current credit count per output port, for debug
err_o  output  2  sticky: [0] credit overflow, [1] illegal destination

Behaviour:
- During and after reset, until the first clock edge after rst falls:
  - port_enable_o=0, port_remove_o=0, port_select_o=all 3'd7, err_o=0.
  - All credit counters = CREDITS; all priority pointers = 0.
- Allocation is combinational from the inputs and the registered pointer/credit state, with zero-cycle latency. Pop and enable are asserted in the same cycle the request is seen.
- Input i requests output j when req_valid_i[i] && req_dest_i[i]==j && j<=4.
- Output j grants when port_mask_i[j]=1, credit[j]!=0 and at least one request exists.
  - Winner = first requesting input at or after ptr[j], searching ascending and wrapping 4->0.
  - Grant sets port_enable_o[j]=1, port_select_o[j]=winner, and port_remove_o[winner]=1.
- Each input carries a single destination, so an input is never granted by two outputs in the same cycle.
- Pointer update: on a grant, ptr[j] <= winner+1, with 5 wrapping to 0. No grant leaves the pointer unchanged.
- Credit counter update per output j, on each clock edge:
  - grant only: decrement.
  - credit_inc_i[j] only: increment.
  - grant and credit_inc_i[j] together: unchanged.
- Credit 0 blocks the port; requesters wait with their FIFO heads held.
- An increment when credit==CREDITS with no same-cycle grant saturates the counter and sets err_o[0].
- req_dest_i > 4 with valid: never granted, never popped; sets err_o[1].
- A request to a masked port is never granted and does not set an error. Routing logic must not generate it.
- err_o bits clear only on rst.
- Asserting rst mid-operation immediately zeroes all outputs and restores credits and pointers. In-flight credit pulses during reset are lost.

Optional Feature:
- Macro ALLOC_STARVE_MON_EN.
- Defined:
  - Adds output port starve_o (5 bits) and parameter STARVE_LIMIT (default 16).
  - Per input, an 8-bit counter increments each cycle req_valid_i is high without a grant, and clears on grant or when the request drops.
  - starve_o[i]=1 while count >= STARVE_LIMIT; the counter saturates at 255.
  - Monitoring only; allocation is unchanged.
- Not defined: no starve_o port, no counters.

Test Plan:
- Reset check: hold rst high, then release -> all outputs idle, port_select_o=all 3'd7, credit_o=4 each, err_o=0.
- Round-robin:
  - Stimulus: inputs 0, 2, 4 all request dest 4 continuously; credits replenished every cycle.
  - Required: grants in order 0, 2, 4, 0, 2; each port_remove_o pulse matches the winner.
- Credit exhaustion and same-cycle update:
  - Input 3 requests dest 1 for 6 cycles with no credit_inc -> 4 grants, then port_enable_o[1]=0 with credit_o[1]=0.
  - A single credit_inc_i[1] pulse -> exactly one further grant.
  - Grant and credit_inc in the same cycle -> count unchanged.
- Mask: port_mask_i=5'b11001, input 4 requests dest 1 -> no grant, no pop, err_o=0. Then dest 3 -> granted.
- Errors:
  - credit_inc_i[0] while credit_o[0]=4 -> counter stays 4, err_o[0]=1 and stays 1.
  - req_dest_i=5 on input 2 -> never popped, err_o[1]=1.
- Reset mid-operation: rst during a stream with credit_o[2]=1 -> outputs drop asynchronously and credit_o[2] reads 4 after release.

Source files
------------

// File: rtl/rr_port_allocator_if.sv
// Handshake bundle between the router datapath and the 5-port output allocator.
// Optional starve_o is present only when ALLOC_STARVE_MON_EN is defined.
interface rr_port_allocator_if #(
  parameter int CREDITS = 4
);
  localparam int CW = $clog2(CREDITS + 1);

  logic [4:0]      req_valid_i;
  logic [14:0]     req_dest_i;
  logic [4:0]      credit_inc_i;
  logic [4:0]      port_mask_i;
  logic [4:0]      port_enable_o;
  logic [14:0]     port_select_o;
  logic [4:0]      port_remove_o;
  logic [5*CW-1:0] credit_o;
  logic [1:0]      err_o;
`ifdef ALLOC_STARVE_MON_EN
  logic [4:0]      starve_o;
`endif

  // Allocator side
  modport slave (
    input  req_valid_i, req_dest_i, credit_inc_i, port_mask_i,
    output port_enable_o, port_select_o, port_remove_o, credit_o, err_o
`ifdef ALLOC_STARVE_MON_EN
    , output starve_o
`endif
  );

  // Router/driver side
  modport master (
    output req_valid_i, req_dest_i, credit_inc_i, port_mask_i,
    input  port_enable_o, port_select_o, port_remove_o, credit_o, err_o
`ifdef ALLOC_STARVE_MON_EN
    , input starve_o
`endif
  );
endinterface

// File: rtl/rr_port_allocator.sv
// Credit-aware round-robin output-port allocator for a 5-port mesh router
// (N=0, S=1, E=2, W=3, L=4). Allocation is combinational (zero latency);
// pointers, credits and sticky errors are registered.
// Optional macro ALLOC_STARVE_MON_EN adds per-input starvation monitors.

// One output port: round-robin pick, pointer and downstream credit counter.
module rr_alloc_port #(
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          active_i,
  input  logic [4:0]    req_i,
  input  logic          mask_i,
  input  logic          inc_i,
  output logic          gnt_o,
  output logic [2:0]    win_o,
  output logic [CW-1:0] credit_o,
  output logic          ovf_o
);
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cred_q, cred_d;
  logic [3:0]    idx;
  logic          found;

  // Search ascending from ptr_q, wrapping 4->0; first requester wins.
  always_comb begin
    found = 1'b0;
    win_o = 3'd0;
    idx   = 4'd0;
    for (int k = 0; k < 5; k++) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx > 4'd4) idx = idx - 4'd5;
      if (!found && req_i[idx[2:0]]) begin
        found = 1'b1;
        win_o = idx[2:0];
      end
    end
    gnt_o = active_i && mask_i && (cred_q != '0) && found;
  end

  // Next pointer and credit; a grant never sees zero credit, so no underflow.
  always_comb begin
    ptr_d  = ptr_q;
    cred_d = cred_q;
    ovf_o  = 1'b0;
    if (gnt_o) ptr_d = (win_o == 3'd4) ? 3'd0 : win_o + 3'd1;
    case ({gnt_o, inc_i})
      2'b10: cred_d = cred_q - 1'b1;
      2'b01: begin
        if (cred_q == CW'(CREDITS)) ovf_o = 1'b1;
        else                        cred_d = cred_q + 1'b1;
      end
      default: cred_d = cred_q;
    endcase
  end

  // Pointer and credit state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= 3'd0;
      cred_q <= CW'(CREDITS);
    end else begin
      ptr_q  <= ptr_d;
      cred_q <= cred_d;
    end
  end

  assign credit_o = cred_q;
endmodule

module rr_port_allocator #(
  parameter int CREDITS = 4
`ifdef ALLOC_STARVE_MON_EN
  , parameter int STARVE_LIMIT = 16
`endif
) (
  input logic           clk,
  input logic           rst,
  rr_port_allocator_if.slave bus
);
  localparam int CW = $clog2(CREDITS + 1);

  logic                 active_q;
  logic [1:0]           err_q;
  logic [4:0][4:0]      req_m;   // [output][input]
  logic [4:0]           gnt;
  logic [4:0][2:0]      win;
  logic [4:0][CW-1:0]   cred;
  logic [4:0]           ovf;
  logic [14:0]          sel;
  logic [4:0]           rem;
  logic                 ill;

  // Outputs stay idle until the first clock edge after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) active_q <= 1'b0;
    else     active_q <= 1'b1;
  end

  // Request matrix; destinations above 4 match no output and are dropped here.
  always_comb begin
    req_m = '0;
    ill   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++)
        req_m[j][i] = bus.req_valid_i[i] && (bus.req_dest_i[3*i +: 3] == 3'(j));
      if (bus.req_valid_i[i] && bus.req_dest_i[3*i +: 3] > 3'd4) ill = 1'b1;
    end
  end

  for (genvar j = 0; j < 5; j++) begin : g_port
    rr_alloc_port #(.CREDITS(CREDITS), .CW(CW)) u_port (
      .clk      (clk),
      .rst      (rst),
      .active_i (active_q),
      .req_i    (req_m[j]),
      .mask_i   (bus.port_mask_i[j]),
      .inc_i    (bus.credit_inc_i[j]),
      .gnt_o    (gnt[j]),
      .win_o    (win[j]),
      .credit_o (cred[j]),
      .ovf_o    (ovf[j])
    );
  end

  // Crossbar select and FIFO pop; one destination per input means no double pop.
  always_comb begin
    sel = '1;
    rem = '0;
    for (int j = 0; j < 5; j++) begin
      if (gnt[j]) begin
        sel[3*j +: 3] = win[j];
        rem[win[j]]   = 1'b1;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 2'b00;
    else     err_q <= err_q | {ill, |ovf};
  end

  assign bus.port_enable_o = gnt;
  assign bus.port_select_o = sel;
  assign bus.port_remove_o = rem;
  assign bus.credit_o      = cred;
  assign bus.err_o         = err_q;

`ifdef ALLOC_STARVE_MON_EN
  logic [4:0][7:0] stv_q;

  // Count cycles a valid head waits without a pop; saturate at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stv_q <= '0;
    else begin
      for (int i = 0; i < 5; i++) begin
        if (!bus.req_valid_i[i] || rem[i]) stv_q[i] <= 8'd0;
        else if (stv_q[i] != 8'hFF)        stv_q[i] <= stv_q[i] + 8'd1;
      end
    end
  end

  // Starvation flags.
  always_comb begin
    bus.starve_o = '0;
    for (int i = 0; i < 5; i++) bus.starve_o[i] = (stv_q[i] >= 8'(STARVE_LIMIT));
  end
`endif
endmodule

// File: tb/tb_rr_port_allocator.sv
// Directed bench for rr_port_allocator: reset, round-robin, credits, mask,
// errors and mid-run reset. Inputs change on negedge; outputs sampled 2ns later.
module tb_rr_port_allocator;
  logic clk = 1'b0;
  logic rst;
  int   errs   = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rr_port_allocator_if #(.CREDITS(4)) bus();

  rr_port_allocator #(.CREDITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] cr(input int j);
    return 32'(bus.credit_o[3*j +: 3]);
  endfunction

  initial begin
    logic [14:0] s;
    int          exp_w[5] = '{0, 2, 4, 0, 2};
    int          ngnt;

    rst = 1'b1;
    bus.req_valid_i  = '0;
    bus.req_dest_i   = '0;
    bus.credit_inc_i = '0;
    bus.port_mask_i  = 5'b11111;

    // Reset state, even with a request pending
    tick(); tick();
    bus.req_valid_i = 5'b00001;
    #2;
    chk("rst_enable", 32'(bus.port_enable_o), 32'h0);
    chk("rst_remove", 32'(bus.port_remove_o), 32'h0);
    chk("rst_select", 32'(bus.port_select_o), 32'h7FFF);
    chk("rst_err",    32'(bus.err_o), 32'h0);
    for (int j = 0; j < 5; j++) chk($sformatf("rst_credit%0d", j), cr(j), 32'd4);
    tick();
    bus.req_valid_i = '0;
    rst = 1'b0;
    tick(); #2;
    chk("post_rst_select", 32'(bus.port_select_o), 32'h7FFF);
    chk("post_rst_err",    32'(bus.err_o), 32'h0);

    // Round robin: inputs 0,2,4 -> dest 4, credits replenished each cycle
    for (int c = 0; c < 5; c++) begin
      tick();
      bus.req_valid_i  = 5'b10101;
      bus.req_dest_i   = {3'd4, 3'd0, 3'd4, 3'd0, 3'd4};
      bus.credit_inc_i = 5'b10000;
      #2;
      s = 15'h7FFF;
      s[14:12] = 3'(exp_w[c]);
      chk($sformatf("rr_enable%0d", c), 32'(bus.port_enable_o), 32'h10);
      chk($sformatf("rr_select%0d", c), 32'(bus.port_select_o), 32'(s));
      chk($sformatf("rr_remove%0d", c), 32'(bus.port_remove_o), 32'(1) << exp_w[c]);
    end
    tick();
    bus.req_valid_i  = '0;
    bus.credit_inc_i = '0;
    #2;
    chk("rr_credit4", cr(4), 32'd4);

    // Credit exhaustion: input 3 -> dest 1 for 6 cycles
    ngnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      bus.req_valid_i = 5'b01000;
      bus.req_dest_i  = 15'd1 << 9;
      #2;
      if (bus.port_enable_o[1]) ngnt++;
      chk($sformatf("ex_enable%0d", c), 32'(bus.port_enable_o[1]), (c < 4) ? 32'd1 : 32'd0);
      chk($sformatf("ex_remove%0d", c), 32'(bus.port_remove_o), (c < 4) ? 32'h8 : 32'h0);
    end
    chk("ex_grants",  32'(ngnt), 32'd4);
    chk("ex_credit0", cr(1), 32'd0);
    // One credit pulse -> exactly one more grant
    tick(); bus.credit_inc_i = 5'b00010; #2;
    chk("one_blocked", 32'(bus.port_enable_o[1]), 32'd0);
    tick(); bus.credit_inc_i = 5'b00000; #2;
    chk("one_grant", 32'(bus.port_enable_o[1]), 32'd1);
    tick(); #2;
    chk("one_after", 32'(bus.port_enable_o[1]), 32'd0);
    chk("one_credit", cr(1), 32'd0);
    // Same-cycle grant and increment
    tick(); bus.credit_inc_i = 5'b00010; #2;         // credit 0 -> 1
    tick(); #2;                                      // grant + inc
    chk("same_grant", 32'(bus.port_enable_o[1]), 32'd1);
    chk("same_pre",   cr(1), 32'd1);
    tick(); bus.credit_inc_i = '0; bus.req_valid_i = '0; #2;
    chk("same_credit", cr(1), 32'd1);
    chk("same_err",    32'(bus.err_o), 32'h0);

    // Mask: ports 0,3,4 present; input 4 -> dest 1 is ignored
    tick();
    bus.port_mask_i = 5'b11001;
    bus.req_valid_i = 5'b10000;
    bus.req_dest_i  = 15'd1 << 12;
    #2;
    chk("mask_enable", 32'(bus.port_enable_o), 32'h0);
    chk("mask_remove", 32'(bus.port_remove_o), 32'h0);
    tick();
    bus.req_dest_i = 15'd3 << 12;
    #2;
    chk("mask_err",     32'(bus.err_o), 32'h0);
    chk("mask3_enable", 32'(bus.port_enable_o), 32'h08);
    chk("mask3_remove", 32'(bus.port_remove_o), 32'h10);
    chk("mask3_select", 32'(bus.port_select_o), 32'h7FFF & ~(32'h7 << 9) | (32'd4 << 9));
    tick();
    bus.req_valid_i = '0;
    bus.port_mask_i = 5'b11111;
    #2;
    chk("mask3_credit", cr(3), 32'd3);

    // Credit overflow on a full port 0
    tick(); bus.credit_inc_i = 5'b00001;
    tick(); bus.credit_inc_i = '0; #2;
    chk("ovf_credit", cr(0), 32'd4);
    chk("ovf_err",    32'(bus.err_o), 32'h1);
    tick(); #2;
    chk("ovf_sticky", 32'(bus.err_o), 32'h1);

    // Illegal destination 5 on input 2
    tick();
    bus.req_valid_i = 5'b00100;
    bus.req_dest_i  = 15'd5 << 6;
    #2;
    chk("ill_remove", 32'(bus.port_remove_o), 32'h0);
    chk("ill_enable", 32'(bus.port_enable_o), 32'h0);
    tick(); #2;
    chk("ill_remove2", 32'(bus.port_remove_o), 32'h0);
    chk("ill_err",     32'(bus.err_o), 32'h3);
    tick(); bus.req_valid_i = '0;

    // Mid-run reset with credit_o[2]=1
    tick();
    bus.req_valid_i = 5'b00001;
    bus.req_dest_i  = 15'd2;
    tick(); tick(); tick(); #2;
    chk("mid_credit", cr(2), 32'd1);
    chk("mid_enable", 32'(bus.port_enable_o), 32'h04);
    rst = 1'b1;
    #1;
    chk("mid_rst_enable", 32'(bus.port_enable_o), 32'h0);
    chk("mid_rst_remove", 32'(bus.port_remove_o), 32'h0);
    chk("mid_rst_select", 32'(bus.port_select_o), 32'h7FFF);
    chk("mid_rst_err",    32'(bus.err_o), 32'h0);
    tick();
    rst = 1'b0;
    #2;
    chk("rel_enable", 32'(bus.port_enable_o), 32'h0);
    tick(); #2;
    chk("rel_credit",  cr(2), 32'd4);
    chk("rel_grant",   32'(bus.port_enable_o), 32'h04);
    // Pointer for port 4 is back at 0: inputs 2,4 -> input 2 wins
    tick();
    bus.req_valid_i = 5'b10100;
    bus.req_dest_i  = {3'd4, 3'd0, 3'd4, 3'd0, 3'd0};
    #2;
    chk("ptr_rst_remove", 32'(bus.port_remove_o), 32'h04);
    tick(); #2;
    chk("ptr_next_remove", 32'(bus.port_remove_o), 32'h10);
    tick(); bus.req_valid_i = '0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
